bullet_scheduler: RTL and testbench
===================================

BULLET_SCHEDULER -- requirements
Module: bullet_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 6: number of bullet slots in the pool.
REQ-002 Parameter STEP_DIV, default 195312: clk cycles per bullet step tick.
REQ-003 Parameter MAX_DIST, default 430: distance in pixels at which a bullet retires.
REQ-004 Port clk, input, 1: system clock, 50 MHz.
REQ-005 Port rst, input, 1: asynchronous reset, active-high.
REQ-006 Port fire, input, 1: raw shoot button, asynchronous, active-high.
REQ-007 Port run, input, 1: 1 = game running, 0 = paused.
REQ-008 Port ship_x / ship_y, input, 11 each: current ship hull top-left corner.
REQ-009 Port kill, input, 1: single-cycle pulse that frees slot kill_idx (enemy hit).
REQ-010 Port kill_idx, input, 3: index of the slot to free.
REQ-011 Port pix_x / pix_y, input, 11 each: current VGA pixel coordinate.
REQ-012 Port pix_hit, output, 1: registered; a live bullet covers the pixel.
REQ-013 Port pix_slot, output, 3: registered; lowest slot index that covers the pixel.
REQ-014 Port active_mask, output, NUM_SLOTS: per-slot alive flags.
REQ-015 Port fire_ack, output, 1: one-cycle pulse when a slot is allocated.
REQ-016 Port fire_drop, output, 1: one-cycle pulse when a fire is rejected because the pool is full.

Function
REQ-017 fire SHALL pass through a 2-flop synchronizer; a fire event is a rising edge of the synchronized signal (fire event at cycle 3 after the raw edge).
REQ-018 Per-slot state SHALL be alive (1b), snap_x (11b), snap_y (11b), dist (9b).
REQ-019 On a fire event with run=1 and at least one free slot, the lowest-index free slot SHALL be loaded: alive=1, snap_x=ship_x, snap_y=ship_y, dist=0; fire_ack pulses in the same cycle.
REQ-020 On a fire event with all slots alive, no state SHALL change and fire_drop pulses.
REQ-021 Fire events with run=0 SHALL be ignored, with neither fire_ack nor fire_drop asserted.
REQ-022 A single prescaler SHALL count 0..STEP_DIV-1 while run=1, hold while run=0, and emit tick at terminal count, then wrap to 0.
REQ-023 On tick, every alive slot SHALL increment dist by 1; if the new dist equals MAX_DIST, the slot SHALL clear alive and dist in that same cycle.
REQ-024 Same-cycle allocate and tick: the newly allocated slot SHALL hold dist=0 and is not stepped.
REQ-025 Same-cycle retire and fire: the retiring slot SHALL count as busy for that allocation and becomes free the next cycle.
REQ-026 kill SHALL clear alive and dist of slot kill_idx; kill takes priority over tick for that slot.
REQ-027 kill with kill_idx >= NUM_SLOTS, or targeting a dead slot, SHALL be a no-op.
REQ-028 Same-cycle kill and fire: the killed slot SHALL count as busy for that allocation.
REQ-029 Pixel test per slot SHALL be: alive, snap_x+5 <= pix_x <= snap_x+7, and snap_y-dist-12 <= pix_y <= snap_y-dist-6.
REQ-030 Pixel-test arithmetic SHALL be signed 13-bit, so a negative lower/upper y bound never wraps into a match.
REQ-031 pix_hit and pix_slot SHALL register the pixel-test result with 1-cycle latency from pix_x/pix_y.
REQ-032 pix_slot SHALL be 0 when pix_hit=0.
REQ-033 active_mask SHALL reflect alive flags directly, with no extra latency.

Reset
REQ-034 While rst=1, all alive, dist, snap_x, snap_y, prescaler and synchronizer flops SHALL be 0, and pix_hit, pix_slot, active_mask, fire_ack, fire_drop SHALL be 0.
REQ-035 rst asserted mid-flight SHALL clear all slots immediately; after release, the first allocation uses slot 0.
REQ-036 A fire level held high across reset release SHALL NOT generate a fire event.

Verification
REQ-037 Fire with ship=(62,452), STEP_DIV=4 -> slot0 alive; pixel (67,440) hit at +1 cycle; after 1 tick, (67,439) hit and (67,446) miss.
REQ-038 Seven fire events with run=1, no ticks -> fire_ack x6, active_mask=6'b111111, fire_drop on the 7th.
REQ-039 Slot at dist=MAX_DIST-1 with a fire event coinciding with its tick -> fire allocates the next free slot (or drops if full); the slot frees the next cycle.
REQ-040 kill_idx=2 with a tick in the same cycle on alive slot2 -> slot2 dead, dist=0; kill_idx=7 -> no change.
REQ-041 ship_y=5, bullet at dist=3, pix_y=2040 -> pix_hit=0 (no wrap).
REQ-042 run=0 for 1000 cycles -> prescaler and dist frozen, fire ignored; run=1 resumes from the held count.

Source files
------------

// File: rtl/bullet_scheduler.sv
// bullet_scheduler: fixed pool of player bullets with synchronized fire,
// one shared step prescaler, kill port and a registered pixel-coverage test.
module bullet_scheduler #(
    parameter int NUM_SLOTS = 6,
    parameter int STEP_DIV  = 195312,
    parameter int MAX_DIST  = 430
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fire,
    input  logic                 run,
    input  logic [10:0]          ship_x,
    input  logic [10:0]          ship_y,
    input  logic                 kill,
    input  logic [2:0]           kill_idx,
    input  logic [10:0]          pix_x,
    input  logic [10:0]          pix_y,
    output logic                 pix_hit,
    output logic [2:0]           pix_slot,
    output logic [NUM_SLOTS-1:0] active_mask,
    output logic                 fire_ack,
    output logic                 fire_drop
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic                 fs1_q, fs2_q, fs3_q;
    logic [1:0]           warm_q;
    logic                 fire_evt;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 tick;
    logic [NUM_SLOTS-1:0] alive_q, alive_d, alloc_oh;
    logic [10:0]          sx_q [NUM_SLOTS];
    logic [10:0]          sx_d [NUM_SLOTS];
    logic [10:0]          sy_q [NUM_SLOTS];
    logic [10:0]          sy_d [NUM_SLOTS];
    logic [8:0]           dist_q [NUM_SLOTS];
    logic [8:0]           dist_d [NUM_SLOTS];
    logic [8:0]           nd;
    logic                 any_free, do_alloc;
    logic signed [12:0]   px, py, xl, xh, yl, yh;
    logic                 hit_d, pix_hit_q;
    logic [2:0]           slot_d, pix_slot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs1_q  <= 1'b0;
            fs2_q  <= 1'b0;
            fs3_q  <= 1'b0;
            warm_q <= 2'd0;
        end else begin
            fs1_q <= fire;
            fs2_q <= fs1_q;
            fs3_q <= fs2_q;
            if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
        end
    end

    // edges count only once the history flop holds post-reset samples
    assign fire_evt = (warm_q == 2'd3) && fs2_q && !fs3_q;

    assign tick = run && (cnt_q == CW'(STEP_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (run) cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_comb begin
        alloc_oh = '0;
        any_free = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!alive_q[i] && !any_free) begin
                alloc_oh[i] = 1'b1;
                any_free    = 1'b1;
            end
        end
    end

    assign do_alloc  = fire_evt && run && any_free;
    assign fire_ack  = do_alloc;
    assign fire_drop = fire_evt && run && !any_free;

    always_comb begin
        alive_d = alive_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        dist_d  = dist_q;
        nd      = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            nd = dist_q[i] + 9'd1;
            if (kill && alive_q[i] && kill_idx == 3'(i)) begin
                alive_d[i] = 1'b0;
                dist_d[i]  = '0;
            end else if (do_alloc && alloc_oh[i]) begin
                alive_d[i] = 1'b1;
                sx_d[i]    = ship_x;
                sy_d[i]    = ship_y;
                dist_d[i]  = '0;
            end else if (tick && alive_q[i]) begin
                if (nd == 9'(MAX_DIST)) begin
                    alive_d[i] = 1'b0;
                    dist_d[i]  = '0;
                end else begin
                    dist_d[i] = nd;
                end
            end
        end
    end

    // signed bounds keep a bullet near the top from wrapping to the bottom
    always_comb begin
        hit_d  = 1'b0;
        slot_d = '0;
        px     = $signed({2'b00, pix_x});
        py     = $signed({2'b00, pix_y});
        xl     = '0;
        xh     = '0;
        yl     = '0;
        yh     = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            xl = $signed({2'b00, sx_q[i]}) + 13'sd5;
            xh = $signed({2'b00, sx_q[i]}) + 13'sd7;
            yl = $signed({2'b00, sy_q[i]}) - $signed({4'b0000, dist_q[i]}) - 13'sd12;
            yh = $signed({2'b00, sy_q[i]}) - $signed({4'b0000, dist_q[i]}) - 13'sd6;
            if (alive_q[i] && px >= xl && px <= xh && py >= yl && py <= yh) begin
                hit_d  = 1'b1;
                slot_d = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            alive_q    <= '0;
            pix_hit_q  <= 1'b0;
            pix_slot_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                sx_q[i]   <= '0;
                sy_q[i]   <= '0;
                dist_q[i] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            alive_q    <= alive_d;
            pix_hit_q  <= hit_d;
            pix_slot_q <= slot_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            dist_q     <= dist_d;
        end
    end

    assign pix_hit     = pix_hit_q;
    assign pix_slot    = pix_slot_q;
    assign active_mask = alive_q;
endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler with STEP_DIV=4; prescaler phase is
// tracked bench-side so tick edges are placed deliberately.
module tb_bullet_scheduler;
    localparam int NS = 6;

    logic          clk = 1'b0;
    logic          rst, fire, run, kill;
    logic [10:0]   ship_x, ship_y, pix_x, pix_y;
    logic [2:0]    kill_idx;
    logic          pix_hit, fire_ack, fire_drop;
    logic [2:0]    pix_slot;
    logic [NS-1:0] active_mask;
    logic          a, d, h;
    logic [2:0]    s;
    int            tests = 0;
    int            fails = 0;
    int            pcnt  = 0;

    always #5 clk = ~clk;

    bullet_scheduler #(
        .NUM_SLOTS(NS),
        .STEP_DIV (4),
        .MAX_DIST (430)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fire       (fire),
        .run        (run),
        .ship_x     (ship_x),
        .ship_y     (ship_y),
        .kill       (kill),
        .kill_idx   (kill_idx),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_hit    (pix_hit),
        .pix_slot   (pix_slot),
        .active_mask(active_mask),
        .fire_ack   (fire_ack),
        .fire_drop  (fire_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        if (run && !rst) pcnt = (pcnt == 3) ? 0 : pcnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic r, input logic kl, input logic [2:0] ki,
                         output logic ack, output logic drp);
        fire = 1'b1;
        cyc();
        cyc();
        run = r;
        kill = kl;
        kill_idx = ki;
        #1;
        ack = fire_ack;
        drp = fire_drop;
        cyc();
        run = 1'b0;
        kill = 1'b0;
        fire = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic probe(input logic [10:0] x, input logic [10:0] y,
                         output logic ph, output logic [2:0] ps);
        pix_x = x;
        pix_y = y;
        cyc();
        ph = pix_hit;
        ps = pix_slot;
    endtask

    task automatic run_ticks(input int n);
        int t = 0;
        run = 1'b1;
        while (t < n) begin
            if (pcnt == 3) t++;
            cyc();
        end
        run = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fire = 1'b0; run = 1'b0; kill = 1'b0; kill_idx = 3'd0;
        ship_x = '0; ship_y = '0; pix_x = '0; pix_y = '0;
        cyc();
        chk("rst_mask", 32'(active_mask), 32'h0);
        chk("rst_hit", 32'(pix_hit), 32'h0);
        chk("rst_slot", 32'(pix_slot), 32'h0);
        chk("rst_ack", 32'(fire_ack), 32'h0);
        chk("rst_drop", 32'(fire_drop), 32'h0);
        rst = 1'b0;
        cyc(); cyc(); cyc();

        // first shot and one step
        ship_x = 11'd62; ship_y = 11'd452;
        press(1'b1, 1'b0, 3'd0, a, d);
        chk("f1_ack", 32'(a), 32'h1);
        chk("f1_drop", 32'(d), 32'h0);
        chk("f1_mask", 32'(active_mask), 32'h01);
        pix_x = 11'd67; pix_y = 11'd440; #1;
        chk("lat_pre", 32'(pix_hit), 32'h0);
        cyc();
        chk("p440_hit", 32'(pix_hit), 32'h1);
        chk("p440_slot", 32'(pix_slot), 32'h0);
        run_ticks(1);
        probe(11'd67, 11'd439, h, s);
        chk("t1_439", 32'(h), 32'h1);
        probe(11'd67, 11'd446, h, s);
        chk("t1_446", 32'(h), 32'h0);
        chk("t1_446_slot", 32'(s), 32'h0);
        probe(11'd66, 11'd439, h, s);
        chk("x66", 32'(h), 32'h0);
        probe(11'd69, 11'd439, h, s);
        chk("x69", 32'(h), 32'h1);
        probe(11'd70, 11'd439, h, s);
        chk("x70", 32'(h), 32'h0);

        // fill the pool; 4th press here coincides with a tick
        ship_x = 11'd100; ship_y = 11'd300;
        for (int k = 0; k < 5; k++) begin
            press(1'b1, 1'b0, 3'd0, a, d);
            chk("fill_ack", 32'(a), 32'h1);
            chk("fill_drop", 32'(d), 32'h0);
        end
        chk("full_mask", 32'(active_mask), 32'h3F);
        press(1'b1, 1'b0, 3'd0, a, d);
        chk("f7_ack", 32'(a), 32'h0);
        chk("f7_drop", 32'(d), 32'h1);
        chk("f7_mask", 32'(active_mask), 32'h3F);
        probe(11'd105, 11'd294, h, s);
        chk("alloc_tick_hit", 32'(h), 32'h1);
        chk("alloc_tick_slot", 32'(s), 32'h4);
        probe(11'd105, 11'd293, h, s);
        chk("lowest_slot", 32'(s), 32'h1);
        probe(11'd105, 11'd295, h, s);
        chk("y295_miss", 32'(h), 32'h0);

        // kill on a tick edge, then out-of-range and dead-slot kills
        run = 1'b1;
        cyc();
        kill = 1'b1; kill_idx = 3'd2;
        cyc();
        run = 1'b0; kill = 1'b0;
        chk("kill2_mask", 32'(active_mask), 32'h3B);
        kill = 1'b1; kill_idx = 3'd7;
        cyc();
        chk("kill7_mask", 32'(active_mask), 32'h3B);
        kill_idx = 3'd2;
        cyc();
        kill = 1'b0;
        chk("killdead_mask", 32'(active_mask), 32'h3B);

        // kill of slot1 coinciding with a fire: slot2 must be chosen
        ship_x = 11'd200; ship_y = 11'd100;
        press(1'b1, 1'b1, 3'd1, a, d);
        chk("kf_ack", 32'(a), 32'h1);
        chk("kf_mask", 32'(active_mask), 32'h3D);
        probe(11'd205, 11'd88, h, s);
        chk("kf_slot", 32'(s), 32'h2);

        // slot0 to dist 429, then retire it on the same edge as a fire
        run_ticks(426);
        probe(11'd67, 11'd11, h, s);
        chk("d429_hit", 32'(h), 32'h1);
        probe(11'd67, 11'd18, h, s);
        chk("d429_y18", 32'(h), 32'h0);
        probe(11'd67, 11'd10, h, s);
        chk("d429_y10", 32'(h), 32'h0);
        run = 1'b1;
        cyc(); cyc(); cyc();
        run = 1'b0;
        press(1'b1, 1'b0, 3'd0, a, d);
        chk("ret_ack", 32'(a), 32'h1);
        chk("ret_drop", 32'(d), 32'h0);
        chk("ret_mask", 32'(active_mask), 32'h3E);
        probe(11'd67, 11'd11, h, s);
        chk("ret_gone", 32'(h), 32'h0);

        // mid-flight reset with fire held across release
        rst = 1'b1; fire = 1'b1;
        cyc();
        chk("rst2_mask", 32'(active_mask), 32'h0);
        chk("rst2_hit", 32'(pix_hit), 32'h0);
        pcnt = 0;
        cyc();
        rst = 1'b0;
        run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("held_ack", 32'(fire_ack), 32'h0);
            chk("held_drop", 32'(fire_drop), 32'h0);
            cyc();
        end
        run = 1'b0; fire = 1'b0;
        cyc(); cyc(); cyc();
        chk("held_mask", 32'(active_mask), 32'h0);

        // bullet near top edge: no wrap of negative y bounds
        ship_x = 11'd300; ship_y = 11'd5;
        press(1'b1, 1'b0, 3'd0, a, d);
        chk("r_ack", 32'(a), 32'h1);
        chk("r_mask", 32'(active_mask), 32'h01);
        run_ticks(3);
        probe(11'd305, 11'd2040, h, s);
        chk("wrap_hit", 32'(h), 32'h0);
        chk("wrap_slot", 32'(s), 32'h0);
        probe(11'd305, 11'd0, h, s);
        chk("top_hit", 32'(h), 32'h0);

        // long pause: fire ignored, prescaler and dist held
        ship_x = 11'd400; ship_y = 11'd600;
        press(1'b1, 1'b0, 3'd0, a, d);
        chk("p_ack", 32'(a), 32'h1);
        run = 1'b1;
        cyc();
        run = 1'b0;
        repeat (495) cyc();
        press(1'b0, 1'b0, 3'd0, a, d);
        chk("pause_ack", 32'(a), 32'h0);
        chk("pause_drop", 32'(d), 32'h0);
        repeat (499) cyc();
        chk("pause_mask", 32'(active_mask), 32'h03);
        run = 1'b1;
        cyc();
        run = 1'b0;
        probe(11'd405, 11'd588, h, s);
        chk("hold_hit", 32'(h), 32'h1);
        chk("hold_slot", 32'(s), 32'h1);
        run = 1'b1;
        cyc();
        run = 1'b0;
        probe(11'd405, 11'd587, h, s);
        chk("resume_hit", 32'(h), 32'h1);
        chk("resume_slot", 32'(s), 32'h1);
        probe(11'd405, 11'd594, h, s);
        chk("resume_miss", 32'(h), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
